instruction_fetcher: RTL and testbench
======================================

# instruction_fetcher

Program store and fetch sequencer that sits directly upstream of the 16-bit multicycle processor. It holds a small program, presents instruction words (and the immediate word after every `mvi`) on the processor's `DIN` bus in the cycles the processor samples them, and tracks the processor's `Done` to pace execution. It raises `Run` while a program is active, stops at a programmed last address, and flags protocol errors.

## Interface
Parameters:
- `ADDR_W`, default 5: program address width, giving a depth of 2^ADDR_W words.
- `DATA_W`, default 16: word width. Must match the processor's `DIN` width.

Ports:
- `Clock`  in  1  : single clock. All logic updates on the rising edge.
- `Reset`  in  1  : synchronous, active-high reset.
- `Start`  in  1  : begin execution from address 0. Honoured only in IDLE or HALT.
- `LoadEn`  in  1  : program write strobe. Honoured only in IDLE or HALT.
- `LoadAddr`  in  ADDR_W  : program write address.
- `LoadData`  in  DATA_W  : program write data.
- `ProgLast`  in  ADDR_W  : address of the last program word. Sampled on `Start`.
- `Done`  in  1  : from the processor; marks an instruction completing this cycle.
- `DIN`  out  DATA_W  : to the processor's instruction/immediate input.
- `Run`  out  1  : high in FETCH, IMM and EXEC.
- `PC`  out  ADDR_W  : current fetch address.
- `Halted`  out  1  : high in HALT.
- `Error`  out  1  : sticky; high in ERROR.
- `InstrCount`  out  16  : number of retired instructions since the last `Start`. Saturates at 0xFFFF.

## Operation
- Program memory is 2^ADDR_W x DATA_W, with synchronous write and asynchronous read.
- `Reset` does not clear memory contents.
- A load writes `mem[LoadAddr] <= LoadData` on the edge where `LoadEn=1`. In any other state the write is dropped.
- `LoadEn` takes priority over `Start` when both are high in the same cycle; the `Start` is ignored.

The opcode is `mem[PC][8:6]`; `001` is `mvi`.

State machine:
- **IDLE:** `DIN=0`, `Run=0`. On `Start` (and `LoadEn=0`): `PC<=0`, latch `ProgLast`, clear `InstrCount`, go to FETCH.
- **FETCH:** `DIN=mem[PC]`.
  - Opcode `mvi` and `PC==ProgLast`: go to ERROR.
  - Opcode `mvi` otherwise: `PC<=PC+1`, go to IMM.
  - Any other opcode: go to EXEC. PC is not advanced yet.
- **IMM:** `DIN=mem[PC]` (the immediate). The cycle is unconditional; `Done` is expected but not checked. The instruction retires.
  - If `PC==ProgLast`, go to HALT.
  - Otherwise `PC<=PC+1` and go to FETCH.
- **EXEC:** `DIN=0`. The wait counter `wcnt` starts at 0 on entry.
  - `Done=1`: the instruction retires. If `PC==ProgLast`, go to HALT; otherwise `PC<=PC+1` and go to FETCH.
  - `Done=0`: `wcnt<=wcnt+1`. If the cycle ends with `wcnt==2`, go to ERROR (no `Done` within 3 EXEC cycles).
- **HALT:** `Run=0`, `Halted=1`, `DIN=0`. PC holds. `Start` restarts exactly as from IDLE. Loads are allowed.
- **ERROR:** `Run=0`, `Error=1`, `DIN=0`. PC holds. Only `Reset` exits.

Other rules:
- A retirement increments `InstrCount` by 1, saturating at 0xFFFF.
- PC never wraps. `ProgLast = 2^ADDR_W-1` halts after the top word.
- `Done` in FETCH, IDLE, HALT or ERROR is ignored.

## Timing
- Reset values: state IDLE, `PC=0`, `DIN=0`, `Run=0`, `Halted=0`, `Error=0`, `InstrCount=0`, `wcnt=0`.
- `Reset` mid-operation wins over every other input on that edge.
- `Start` sampled at edge k puts FETCH at cycle k+1, with `DIN` valid combinationally in that cycle. The processor captures its IR at the end of FETCH.
- Cycles per instruction:
  - `mvi`: 2 (FETCH, IMM).
  - `mv`: 2 (FETCH, EXEC with `Done` in the first EXEC cycle).
  - ALU ops: 4 (FETCH, then EXEC for 3 cycles with `Done` in the third).
- `Halted` and `Run=0` appear the cycle after the last retirement.
- `Error` appears the cycle after the detecting cycle.

## Test plan
- **mvi then mv.** Load 0x0040, 0x0005, 0x0008 with `ProgLast=2`, then `Start`; drive `Done` in the IMM cycle and the first EXEC cycle. Required `DIN` sequence: 0x0040, 0x0005, 0x0008, 0x0000. Then `Halted=1`, `InstrCount=2`, `PC=2`.
- **add with late Done.** Program 0x0091, `ProgLast=0`; `Done` in the third EXEC cycle. Required: `Run` high for 4 cycles, then `Halted=1` and `InstrCount=1`.
- **Watchdog.** Program 0x0091 with `Done` held 0. Required: `Error=1` in the cycle after the third EXEC cycle, and `Run=0`. `Start` is then ignored; `Reset` clears `Error`.
- **mvi at last address.** Program 0x0040 with `ProgLast=0`. Required: ERROR straight from FETCH, `InstrCount=0`.
- **Illegal load.** Pulse `LoadEn` to address 1 while in EXEC. Required: the memory word is unchanged on readback after HALT.
- **Reset mid-run, then restart.** `Reset` during EXEC gives all outputs at reset values on the next cycle. A later `Start` reruns from `PC=0` with memory intact.

Source files
------------

// File: rtl/instruction_fetcher_if.sv
// Bus between the instruction fetcher and the surrounding processor/loader.
// The fetcher is the slave; the processor side and program loader form the master.
interface instruction_fetcher_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              Start;
  logic              LoadEn;
  logic [ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0] LoadData;
  logic [ADDR_W-1:0] ProgLast;
  logic              Done;
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic              Halted;
  logic              Error;
  logic [15:0]       InstrCount;

  modport master (
    output Start, LoadEn, LoadAddr, LoadData, ProgLast, Done,
    input  DIN, Run, PC, Halted, Error, InstrCount
  );

  modport slave (
    input  Start, LoadEn, LoadAddr, LoadData, ProgLast, Done,
    output DIN, Run, PC, Halted, Error, InstrCount
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Program store and fetch sequencer feeding the 16-bit multicycle processor's DIN bus.
// Paces execution on Done, halts at the programmed last address, and traps protocol errors.
module instruction_fetcher #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input logic                  Clock,
  input logic                  Reset,
  instruction_fetcher_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_IMM   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [ADDR_W-1:0] last_r, last_nxt_s;
  logic [15:0]       cnt_r, cnt_nxt_s;
  logic [1:0]        wcnt_r, wcnt_nxt_s;
  logic              run_r, halted_r, error_r;
  logic              retire_s;
  logic              load_ok_s;
  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] din_s;
  logic              is_mvi_s;
  logic              at_last_s;

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign word_s    = mem_r[pc_r];
  assign is_mvi_s  = (word_s[8:6] == 3'b001);
  assign at_last_s = (pc_r == last_r);
  assign load_ok_s = bus.LoadEn && ((state_r == ST_IDLE) || (state_r == ST_HALT));

  // Program store: loads only while parked; a coincident Reset drops the write.
  always_ff @(posedge Clock) begin
    if (!Reset && load_ok_s) begin
      mem_r[bus.LoadAddr] <= bus.LoadData;
    end
  end

  // Next-state, PC, watchdog and retirement decisions.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    last_nxt_s  = last_r;
    cnt_nxt_s   = cnt_r;
    wcnt_nxt_s  = wcnt_r;
    retire_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (bus.Start && !bus.LoadEn) begin
          pc_nxt_s    = {ADDR_W{1'b0}};
          last_nxt_s  = bus.ProgLast;
          cnt_nxt_s   = 16'd0;
          wcnt_nxt_s  = 2'd0;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_FETCH: begin
        if (is_mvi_s && at_last_s) begin
          state_nxt_s = ST_ERROR;
        end else if (is_mvi_s) begin
          pc_nxt_s    = pc_r + PC_ONE;
          state_nxt_s = ST_IMM;
        end else begin
          wcnt_nxt_s  = 2'd0;
          state_nxt_s = ST_EXEC;
        end
      end
      ST_IMM: begin
        retire_s = 1'b1;
        if (at_last_s) begin
          state_nxt_s = ST_HALT;
        end else begin
          pc_nxt_s    = pc_r + PC_ONE;
          state_nxt_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (bus.Done) begin
          retire_s   = 1'b1;
          wcnt_nxt_s = 2'd0;
          if (at_last_s) begin
            state_nxt_s = ST_HALT;
          end else begin
            pc_nxt_s    = pc_r + PC_ONE;
            state_nxt_s = ST_FETCH;
          end
        end else begin
          // Third EXEC cycle without Done trips the watchdog.
          wcnt_nxt_s = wcnt_r + 2'd1;
          if (wcnt_r == 2'd2) begin
            state_nxt_s = ST_ERROR;
          end else begin
            state_nxt_s = ST_EXEC;
          end
        end
      end
      ST_ERROR: begin
        state_nxt_s = ST_ERROR;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (retire_s) begin
      cnt_nxt_s = sat_inc(cnt_r);
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // State and status registers; status flags are decoded from the next state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      pc_r     <= {ADDR_W{1'b0}};
      last_r   <= {ADDR_W{1'b0}};
      cnt_r    <= 16'd0;
      wcnt_r   <= 2'd0;
      run_r    <= 1'b0;
      halted_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      last_r   <= last_nxt_s;
      cnt_r    <= cnt_nxt_s;
      wcnt_r   <= wcnt_nxt_s;
      run_r    <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_IMM) ||
                  (state_nxt_s == ST_EXEC);
      halted_r <= (state_nxt_s == ST_HALT);
      error_r  <= (state_nxt_s == ST_ERROR);
    end
  end

  // The processor samples DIN in the same cycle, so it comes straight off the memory read.
  always_comb begin
    din_s = {DATA_W{1'b0}};
    case (state_r)
      ST_FETCH, ST_IMM: din_s = word_s;
      default:          din_s = {DATA_W{1'b0}};
    endcase
  end

  assign bus.DIN        = din_s;
  assign bus.Run        = run_r;
  assign bus.PC         = pc_r;
  assign bus.Halted     = halted_r;
  assign bus.Error      = error_r;
  assign bus.InstrCount = cnt_r;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Scoreboard bench for instruction_fetcher: a program-walking reference model predicts
// the DIN word stream and the final status; a monitor pops expected words while Run is high.
module tb_instruction_fetcher;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetcher_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  instruction_fetcher #(.ADDR_W(AW), .DATA_W(DW)) dut (.Clock(clk), .Reset(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_mem [DEPTH];
  logic [15:0] exp_q [$];
  logic [15:0] tr_din [$];
  bit          tr_done [$];
  int          exp_end;   // 0 = halted, 1 = error
  int          exp_cnt;
  int          exp_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every cycle with Run high must carry the next predicted DIN word.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.Run === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL run_extra: Run high with no predicted word, DIN=%0h", bus.DIN);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bus.DIN !== e) begin
            bad++;
            $display("FAIL din: got %0h, required %0h", bus.DIN, e);
          end
        end
      end
    end
  end

  function automatic int pick_latency(input int mode);
    if (mode >= 1 && mode <= 4) return mode;
    if (mode == 5 && $urandom_range(0, 15) == 0) return 4;
    return int'($urandom_range(1, 3));
  endfunction

  // Reference: walk the program by instruction, listing per-cycle DIN and the Done to drive.
  function automatic void build_trace(input int last, input int mode);
    int pc;
    int lat;
    logic [15:0] w;
    bit fd;
    pc = 0;
    exp_cnt = 0;
    tr_din.delete();
    tr_done.delete();
    while (1) begin
      w  = ref_mem[pc];
      fd = 1'($urandom_range(0, 1));
      tr_din.push_back(w);
      tr_done.push_back(fd);
      if (w[8:6] == 3'b001) begin
        if (pc == last) begin
          exp_end = 1; exp_pc = pc; return;
        end
        pc++;
        tr_din.push_back(ref_mem[pc]);
        tr_done.push_back(1'b1);
        exp_cnt++;
      end else begin
        lat = pick_latency(mode);
        if (lat > 3) begin
          for (int k = 0; k < 3; k++) begin
            tr_din.push_back(16'h0000); tr_done.push_back(1'b0);
          end
          exp_end = 1; exp_pc = pc; return;
        end
        for (int k = 1; k < lat; k++) begin
          tr_din.push_back(16'h0000); tr_done.push_back(1'b0);
        end
        tr_din.push_back(16'h0000);
        tr_done.push_back(1'b1);
        exp_cnt++;
      end
      if (pc == last) begin
        exp_end = 0; exp_pc = pc; return;
      end
      pc++;
    end
  endfunction

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_run"},    {31'd0, bus.Run},    32'd0);
    check({tag, "_din"},    {16'd0, bus.DIN},    32'd0);
    check({tag, "_pc"},     {27'd0, bus.PC},     32'd0);
    check({tag, "_halted"}, {31'd0, bus.Halted}, 32'd0);
    check({tag, "_error"},  {31'd0, bus.Error},  32'd0);
    check({tag, "_icount"}, {16'd0, bus.InstrCount}, 32'd0);
  endtask

  task automatic load_word(input int addr, input logic [15:0] data, input bit with_start);
    bus.LoadEn   = 1'b1;
    bus.LoadAddr = 5'(addr);
    bus.LoadData = data;
    bus.Start    = with_start;
    @(posedge clk); #1;
    bus.LoadEn = 1'b0;
    bus.Start  = 1'b0;
    ref_mem[addr] = data;
  endtask

  // Run one program; abort_at > 0 asserts Reset in trace cycle abort_at-1.
  task automatic run_prog(input int last, input int mode, input int abort_at);
    int n;
    bit aborting;
    build_trace(last, mode);
    aborting = (abort_at > 0) && (abort_at < tr_din.size());
    n = aborting ? abort_at : tr_din.size();
    for (int i = 0; i < n; i++) exp_q.push_back(tr_din[i]);
    bus.ProgLast = 5'(last);
    bus.Start    = 1'b1;
    @(posedge clk); #1;
    bus.Start    = 1'b0;
    bus.ProgLast = 5'($urandom);
    for (int i = 0; i < n; i++) begin
      bus.Done     = tr_done[i];
      bus.LoadEn   = (i == 1) || ($urandom_range(0, 7) == 0);
      bus.LoadAddr = (i == 1) ? 5'd1 : 5'($urandom);
      bus.LoadData = 16'($urandom);
      bus.Start    = ($urandom_range(0, 7) == 0);
      if (aborting && i == n - 1) rst = 1'b1;
      @(posedge clk); #1;
    end
    bus.Done   = 1'b0;
    bus.LoadEn = 1'b0;
    bus.Start  = 1'b0;
    rst        = 1'b0;
    if (aborting) begin
      check_reset_vals("abort");
    end else begin
      @(negedge clk);
      check("end_run",    {31'd0, bus.Run},    32'd0);
      check("end_halted", {31'd0, bus.Halted}, (exp_end == 0) ? 32'd1 : 32'd0);
      check("end_error",  {31'd0, bus.Error},  (exp_end == 1) ? 32'd1 : 32'd0);
      check("end_icount", {16'd0, bus.InstrCount}, 32'(exp_cnt));
      check("end_pc",     {27'd0, bus.PC},     32'(exp_pc));
    end
    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic after_error();
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start    = 1'b0;
    bus.LoadEn   = 1'b1;
    bus.LoadAddr = 5'($urandom);
    bus.LoadData = 16'($urandom);
    @(posedge clk); #1;
    bus.LoadEn = 1'b0;
    @(negedge clk);
    check("err_sticky", {31'd0, bus.Error}, 32'd1);
    check("err_run",    {31'd0, bus.Run},   32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("err_clear");
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 9) < 3) w[8:6] = 3'b001;
    else if (w[8:6] == 3'b001) w[8:6] = 3'b010;
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    bus.Start = 1'b0; bus.LoadEn = 1'b0; bus.LoadAddr = '0;
    bus.LoadData = '0; bus.ProgLast = '0; bus.Done = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("reset");
    for (int a = 0; a < DEPTH; a++) load_word(a, rand_word(), 1'b0);

    // mvi then mv
    load_word(0, 16'h0040, 1'b0);
    load_word(1, 16'h0005, 1'b0);
    load_word(2, 16'h0008, 1'b0);
    run_prog(2, 1, 0);
    // load beats Start in HALT
    load_word(3, 16'h1234, 1'b1);
    @(negedge clk);
    check("load_prio_run",    {31'd0, bus.Run},    32'd0);
    check("load_prio_halted", {31'd0, bus.Halted}, 32'd1);

    // add with late Done
    load_word(0, 16'h0091, 1'b0);
    run_prog(0, 3, 0);
    // watchdog
    run_prog(0, 4, 0);
    after_error();
    // mvi at last address
    load_word(0, 16'h0040, 1'b0);
    run_prog(0, 1, 0);
    after_error();
    // mvi/mv program again: word 1 survived the dropped loads
    load_word(0, 16'h0040, 1'b0);
    run_prog(2, 1, 0);
    // reset mid-EXEC, then rerun
    load_word(0, 16'h0091, 1'b0);
    run_prog(0, 3, 2);
    run_prog(0, 3, 0);
    // full depth, no wrap
    for (int a = 0; a < DEPTH; a++) load_word(a, 16'h0008, 1'b0);
    run_prog(DEPTH - 1, 1, 0);

    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 6; k++) load_word(int'($urandom_range(0, DEPTH - 1)), rand_word(), 1'b0);
      run_prog(int'($urandom_range(0, DEPTH - 1)), 5, 0);
      if (exp_end == 1) after_error();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
